// File: rtl/fx2_fifo_model.sv
// Behavioural model of an FX2 slave FIFO pair: an IN buffer filled from the FPGA bus and drained by the host,
// and an OUT buffer loaded by the host and read over the bus. Define FX2_MODEL_BUSCHK_EN to build the bus-protocol checker.
`timescale 1ns/1ps
module fx2_fifo_model #(
   parameter int DEPTH_LOG2 = 9,
   parameter int PKT_WORDS  = 256
) (
   input  logic                  i_clk_usb,
   input  logic                  i_rst_n,
   input  logic                  i_slcs,
   input  logic                  i_addr0,
   input  logic                  i_addr1,
   input  logic                  i_sloe,
   input  logic                  i_slrd,
   input  logic                  i_slwr,
   input  logic                  i_slpked,
   inout  wire  [15:0]           io_data,
   output logic                  o_flagb,
   output logic                  o_flagc,
   input  logic                  i_host_wr,
   input  logic [15:0]           i_host_wdata,
   input  logic                  i_host_commit,
   input  logic                  i_host_rd,
   output logic [15:0]           o_host_rdata,
   output logic [DEPTH_LOG2:0]   o_host_avail,
   output logic [7:0]            o_zlp_cnt,
   output logic                  o_err
);

   localparam int                 DEPTH   = 1 << DEPTH_LOG2;
   localparam int                 CW      = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] PKT_W   = PKT_WORDS[DEPTH_LOG2:0];

   typedef enum logic [1:0] {IN_IDLE, IN_FILL, IN_FULL} in_state_t;
   typedef enum logic [1:0] {OUT_EMPTY, OUT_STAGED, OUT_READY} out_state_t;

   in_state_t               r_in_state, w_in_state_nxt;
   out_state_t              r_out_state, w_out_state_nxt;

   logic [15:0]             r_in_mem  [0:DEPTH-1];
   logic [15:0]             r_out_mem [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0]   r_in_wptr, r_in_rptr, r_out_wptr, r_out_rptr;
   logic [DEPTH_LOG2:0]     r_in_count, r_in_pend, r_in_avail;
   logic [DEPTH_LOG2:0]     r_out_total, r_out_staged, r_out_commit;
   logic                    r_pktend_q;
   logic [7:0]              r_zlp_cnt;

   logic                    w_in_sel, w_out_sel, w_in_push, w_in_pop, w_pktend_lvl;
   logic                    w_out_wr, w_out_pop, w_in_commit, w_zlp_evt, w_drive;
   logic [DEPTH_LOG2:0]     w_in_pend_inc, w_in_pend_nxt, w_in_avail_nxt, w_in_count_nxt;
   logic [DEPTH_LOG2:0]     w_out_staged_inc, w_out_staged_nxt, w_out_commit_nxt, w_out_total_nxt;
   logic [15:0]             w_out_head;

   assign w_in_sel     = ~i_slcs &  i_addr1 & ~i_addr0;
   assign w_out_sel    = ~i_slcs & ~i_addr1 & ~i_addr0;
   assign w_pktend_lvl = w_in_sel & ~i_slpked;
   assign w_in_push    = w_in_sel & ~i_slwr & o_flagb;
   assign w_in_pop     = i_host_rd & (r_in_avail != '0);
   assign w_out_wr     = i_host_wr & (r_out_total != DEPTH_W);
   assign w_out_pop    = w_out_sel & ~i_slrd & o_flagc;

   // A pushed word joins the pending packet before the commit decision, so pktend on the same edge includes it.
   always_comb begin
      w_in_pend_inc  = r_in_pend + CW'(w_in_push);
      w_in_commit    = (w_in_pend_inc == PKT_W) | w_pktend_lvl;
      w_in_pend_nxt  = w_in_commit ? '0 : w_in_pend_inc;
      w_in_avail_nxt = r_in_avail - CW'(w_in_pop) + (w_in_commit ? w_in_pend_inc : '0);
      w_in_count_nxt = r_in_count + CW'(w_in_push) - CW'(w_in_pop);
      w_in_state_nxt = IN_IDLE;
      if (w_in_count_nxt == DEPTH_W)
         w_in_state_nxt = IN_FULL;
      else if (w_in_pend_nxt != '0)
         w_in_state_nxt = IN_FILL;
   end

   always_comb begin
      w_out_staged_inc = r_out_staged + CW'(w_out_wr);
      w_out_staged_nxt = i_host_commit ? '0 : w_out_staged_inc;
      w_out_commit_nxt = r_out_commit - CW'(w_out_pop) + (i_host_commit ? w_out_staged_inc : '0);
      w_out_total_nxt  = r_out_total + CW'(w_out_wr) - CW'(w_out_pop);
      w_out_state_nxt  = OUT_EMPTY;
      if (w_out_commit_nxt != '0)
         w_out_state_nxt = OUT_READY;
      else if (w_out_staged_nxt != '0)
         w_out_state_nxt = OUT_STAGED;
   end

   always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_in_state  <= IN_IDLE;
         r_out_state <= OUT_EMPTY;
      end else begin
         r_in_state  <= w_in_state_nxt;
         r_out_state <= w_out_state_nxt;
      end
   end

   always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_in_wptr    <= '0;
         r_in_rptr    <= '0;
         r_in_count   <= '0;
         r_in_pend    <= '0;
         r_in_avail   <= '0;
         r_out_wptr   <= '0;
         r_out_rptr   <= '0;
         r_out_total  <= '0;
         r_out_staged <= '0;
         r_out_commit <= '0;
      end else begin
         if (w_in_push)  r_in_wptr  <= r_in_wptr + 1'b1;
         if (w_in_pop)   r_in_rptr  <= r_in_rptr + 1'b1;
         if (w_out_wr)   r_out_wptr <= r_out_wptr + 1'b1;
         if (w_out_pop)  r_out_rptr <= r_out_rptr + 1'b1;
         r_in_count   <= w_in_count_nxt;
         r_in_pend    <= w_in_pend_nxt;
         r_in_avail   <= w_in_avail_nxt;
         r_out_total  <= w_out_total_nxt;
         r_out_staged <= w_out_staged_nxt;
         r_out_commit <= w_out_commit_nxt;
      end
   end

   // Buffer storage carries no reset; clearing the pointers and counts is what discards the contents.
   always_ff @(posedge i_clk_usb) begin
      if (w_in_push) r_in_mem[r_in_wptr]   <= io_data;
      if (w_out_wr)  r_out_mem[r_out_wptr] <= i_host_wdata;
   end

   // Only the first edge of a held pktend can count as a zero-length packet.
   assign w_zlp_evt = w_pktend_lvl & ~r_pktend_q & (w_in_pend_inc == '0);

   always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pktend_q <= 1'b0;
         r_zlp_cnt  <= '0;
      end else begin
         r_pktend_q <= w_pktend_lvl;
         if (w_zlp_evt && r_zlp_cnt != 8'hFF)
            r_zlp_cnt <= r_zlp_cnt + 8'd1;
      end
   end

   assign o_flagb      = (r_in_state != IN_FULL);
   assign o_flagc      = (r_out_state == OUT_READY);
   assign o_host_avail = r_in_avail;
   assign o_host_rdata = (r_in_avail != '0) ? r_in_mem[r_in_rptr] : 16'h0000;
   assign o_zlp_cnt    = r_zlp_cnt;

   assign w_out_head = (r_out_commit != '0) ? r_out_mem[r_out_rptr] : 16'h0000;
   assign w_drive    = w_out_sel & ~i_sloe & i_rst_n;
   assign io_data    = w_drive ? w_out_head : 16'hzzzz;

`ifdef FX2_MODEL_BUSCHK_EN
   logic r_err;
   logic w_err_evt;

   // Read and write strobes together, writes into a full IN buffer, reads of an empty OUT buffer, or OE on the IN address.
   assign w_err_evt = ~i_slcs & ((~i_slwr & ~i_slrd) |
                                 (w_in_sel & ~i_slwr & ~o_flagb) |
                                 (w_out_sel & ~i_slrd & ~o_flagc) |
                                 (~i_sloe & i_addr1));

   always_ff @(posedge i_clk_usb or negedge i_rst_n) begin
      if (!i_rst_n)
         r_err <= 1'b0;
      else if (w_err_evt)
         r_err <= 1'b1;
   end

   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fx2_fifo_model.sv
// Directed bench for fx2_fifo_model: a vector table for the IN path plus hand sequences for
// the OUT path, auto-commit, full buffer, pointer wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_fx2_fifo_model;

   logic        clk = 1'b0;
   logic        rstN;
   logic        slcs, addr0, addr1, sloe, slrd, slwr, slpked;
   logic        hostWr, hostCommit, hostRd;
   logic [15:0] hostWdata;
   logic [15:0] hostRdata;
   logic [9:0]  hostAvail;
   logic [7:0]  zlpCnt;
   logic        flagb, flagc, err;
   wire  [15:0] dataBus;
   logic [15:0] tbData;
   logic        tbDrive;

   int testsRun    = 0;
   int testsFailed = 0;

   assign dataBus = tbDrive ? tbData : 16'hzzzz;

   always #5 clk = ~clk;

   fx2_fifo_model #(.DEPTH_LOG2(9), .PKT_WORDS(256)) dut (
      .i_clk_usb     (clk),
      .i_rst_n       (rstN),
      .i_slcs        (slcs),
      .i_addr0       (addr0),
      .i_addr1       (addr1),
      .i_sloe        (sloe),
      .i_slrd        (slrd),
      .i_slwr        (slwr),
      .i_slpked      (slpked),
      .io_data       (dataBus),
      .o_flagb       (flagb),
      .o_flagc       (flagc),
      .i_host_wr     (hostWr),
      .i_host_wdata  (hostWdata),
      .i_host_commit (hostCommit),
      .i_host_rd     (hostRd),
      .o_host_rdata  (hostRdata),
      .o_host_avail  (hostAvail),
      .o_zlp_cnt     (zlpCnt),
      .o_err         (err)
   );

   typedef struct {
      logic        inWr;
      logic        pktEnd;
      logic [15:0] inData;
      logic        hostRd;
      logic [9:0]  expAvail;
      logic [15:0] expRdata;
      logic [7:0]  expZlp;
   } vec_t;

   vec_t        vecs[18];
   logic [15:0] outWords[4];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      slcs = 1'b1; addr0 = 1'b0; addr1 = 1'b0;
      sloe = 1'b1; slrd = 1'b1; slwr = 1'b1; slpked = 1'b1;
      hostWr = 1'b0; hostWdata = 16'h0; hostCommit = 1'b0; hostRd = 1'b0;
      tbDrive = 1'b0; tbData = 16'h0;
   endtask

   task automatic applyStimulus(input logic inWr, input logic pktEnd, input logic [15:0] data, input logic rd);
      slcs    = ~(inWr | pktEnd);
      addr1   = 1'b1;
      addr0   = 1'b0;
      slwr    = ~inWr;
      slpked  = ~pktEnd;
      tbDrive = inWr;
      tbData  = data;
      hostRd  = rd;
   endtask

   task automatic doReset();
      setIdle();
      rstN = 1'b0;
      repeat (2) tick();
      rstN = 1'b1;
      tick();
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 10'd0, 16'h0000, 8'd0};
      vecs[1]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 10'd0, 16'h0000, 8'd0};
      vecs[2]  = '{1'b1, 1'b0, 16'h0003, 1'b0, 10'd0, 16'h0000, 8'd0};
      vecs[3]  = '{1'b1, 1'b0, 16'h0004, 1'b0, 10'd0, 16'h0000, 8'd0};
      vecs[4]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 10'd4, 16'h0001, 8'd0};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 10'd3, 16'h0002, 8'd0};
      vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 10'd2, 16'h0003, 8'd0};
      vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 10'd1, 16'h0004, 8'd0};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 16'h0000, 8'd0};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 16'h0000, 8'd0};
      vecs[10] = '{1'b0, 1'b1, 16'h0000, 1'b0, 10'd0, 16'h0000, 8'd1};
      vecs[11] = '{1'b0, 1'b1, 16'h0000, 1'b0, 10'd0, 16'h0000, 8'd1};
      vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 10'd0, 16'h0000, 8'd1};
      vecs[13] = '{1'b1, 1'b1, 16'h00AA, 1'b0, 10'd1, 16'h00AA, 8'd1};
      vecs[14] = '{1'b1, 1'b0, 16'h00BB, 1'b1, 10'd0, 16'h0000, 8'd1};
      vecs[15] = '{1'b0, 1'b1, 16'h0000, 1'b0, 10'd1, 16'h00BB, 8'd1};
      vecs[16] = '{1'b1, 1'b1, 16'h00CC, 1'b1, 10'd1, 16'h00CC, 8'd1};
      vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 10'd0, 16'h0000, 8'd1};
      outWords = '{16'h1234, 16'hEDCB, 16'h0000, 16'h0010};

      // Reset values, sampled while reset is still asserted
      setIdle();
      rstN = 1'b0;
      repeat (2) tick();
      checkOutput("rst_flagb", 32'(flagb), 32'd1);
      checkOutput("rst_flagc", 32'(flagc), 32'd0);
      checkOutput("rst_avail", 32'(hostAvail), 32'd0);
      checkOutput("rst_rdata", 32'(hostRdata), 32'd0);
      checkOutput("rst_zlp", 32'(zlpCnt), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      rstN = 1'b1;
      tick();

      // IN path vector table
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].inWr, vecs[i].pktEnd, vecs[i].inData, vecs[i].hostRd);
         tick();
         checkOutput($sformatf("vec%0d_avail", i), 32'(hostAvail), 32'(vecs[i].expAvail));
         checkOutput($sformatf("vec%0d_rdata", i), 32'(hostRdata), 32'(vecs[i].expRdata));
         checkOutput($sformatf("vec%0d_zlp", i), 32'(zlpCnt), 32'(vecs[i].expZlp));
         checkOutput($sformatf("vec%0d_flagb", i), 32'(flagb), 32'd1);
      end
      setIdle();
      tick();

      // OUT path: staged words stay invisible until commit, then read over the bus
      hostWr = 1'b1;
      for (int k = 0; k < 4; k++) begin
         hostWdata = outWords[k];
         tick();
         checkOutput("out_stage_flagc", 32'(flagc), 32'd0);
      end
      hostWr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         checkOutput("out_nocommit_flagc", 32'(flagc), 32'd0);
      end
      hostCommit = 1'b1;
      tick();
      hostCommit = 1'b0;
      checkOutput("out_commit_flagc", 32'(flagc), 32'd1);
      slcs = 1'b0; addr1 = 1'b0; addr0 = 1'b0;
      sloe = 1'b1; tbDrive = 1'b1; tbData = 16'h0000;
      #1;
      checkOutput("out_oe_off_bus", 32'(dataBus), 32'h0000);
      tbDrive = 1'b0;
      sloe = 1'b0;
      slrd = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         checkOutput($sformatf("out_bus%0d", k), 32'(dataBus), 32'(outWords[k]));
         checkOutput($sformatf("out_flagc%0d", k), 32'(flagc), 32'd1);
         tick();
      end
      slrd = 1'b1;
      #1;
      checkOutput("out_empty_flagc", 32'(flagc), 32'd0);
      checkOutput("out_empty_bus", 32'(dataBus), 32'h0000);
      setIdle();

      // Auto-commit at 256 words, then a lone pktend is a zero-length packet
      doReset();
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 1'b0, 16'(16'h1000 + i), 1'b0);
         tick();
         if (i == 254) checkOutput("auto_before", 32'(hostAvail), 32'd0);
      end
      checkOutput("auto_avail", 32'(hostAvail), 32'd256);
      checkOutput("auto_rdata", 32'(hostRdata), 32'h1000);
      applyStimulus(1'b0, 1'b1, 16'h0, 1'b0);
      tick();
      checkOutput("zlp_after_auto", 32'(zlpCnt), 32'd1);
      checkOutput("zlp_avail", 32'(hostAvail), 32'd256);
      setIdle();
      tick();

      // Fill to 512, drop the 513th write, drain one, then wrap the write pointer
      for (int i = 256; i < 512; i++) begin
         applyStimulus(1'b1, 1'b0, 16'(16'h1000 + i), 1'b0);
         tick();
         if (i == 510) checkOutput("full_flagb_511", 32'(flagb), 32'd1);
      end
      checkOutput("full_flagb_512", 32'(flagb), 32'd0);
      checkOutput("full_avail", 32'(hostAvail), 32'd512);
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 1'b0);
      tick();
      checkOutput("drop_avail", 32'(hostAvail), 32'd512);
      checkOutput("drop_flagb", 32'(flagb), 32'd0);
      checkOutput("drop_err", 32'(err), 32'd0);
      applyStimulus(1'b0, 1'b0, 16'h0, 1'b1);
      tick();
      checkOutput("drain1_avail", 32'(hostAvail), 32'd511);
      checkOutput("drain1_flagb", 32'(flagb), 32'd1);
      applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b0);
      tick();
      checkOutput("wrap_avail", 32'(hostAvail), 32'd512);
      checkOutput("wrap_flagb", 32'(flagb), 32'd0);
      checkOutput("wrap_zlp", 32'(zlpCnt), 32'd1);
      setIdle();
      hostRd = 1'b1;
      for (int i = 1; i < 512; i++) begin
         checkOutput($sformatf("drain_word%0d", i), 32'(hostRdata), 32'(16'h1000 + i));
         tick();
      end
      checkOutput("drain_wrapped", 32'(hostRdata), 32'hBEEF);
      tick();
      hostRd = 1'b0;
      checkOutput("drain_done_avail", 32'(hostAvail), 32'd0);
      checkOutput("drain_done_flagb", 32'(flagb), 32'd1);

      // Asynchronous reset with IN pending and OUT committed data
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 1'b0, 16'(16'h2000 + i), 1'b0);
         hostWr     = (i < 8);
         hostWdata  = 16'(16'h3000 + i);
         hostCommit = (i == 7);
         tick();
      end
      setIdle();
      checkOutput("pre_rst_avail", 32'(hostAvail), 32'd0);
      checkOutput("pre_rst_flagc", 32'(flagc), 32'd1);
      #3;
      rstN = 1'b0;
      slcs = 1'b0; addr1 = 1'b0; addr0 = 1'b0;
      tbDrive = 1'b1; tbData = 16'h5A5A;
      #1;
      checkOutput("arst_avail", 32'(hostAvail), 32'd0);
      checkOutput("arst_flagb", 32'(flagb), 32'd1);
      checkOutput("arst_flagc", 32'(flagc), 32'd0);
      checkOutput("arst_zlp", 32'(zlpCnt), 32'd0);
      checkOutput("arst_rdata", 32'(hostRdata), 32'd0);
      checkOutput("arst_bus", 32'(dataBus), 32'h5A5A);
      setIdle();
      #2;
      rstN = 1'b1;
      tick();
      checkOutput("post_rst_flagc", 32'(flagc), 32'd0);
      applyStimulus(1'b1, 1'b1, 16'h7777, 1'b0);
      tick();
      checkOutput("post_rst_avail", 32'(hostAvail), 32'd1);
      checkOutput("post_rst_rdata", 32'(hostRdata), 32'h7777);
      setIdle();
      slcs = 1'b0; addr1 = 1'b0; addr0 = 1'b0; sloe = 1'b0;
      #1;
      checkOutput("post_rst_out_bus", 32'(dataBus), 32'h0000);
      setIdle();
      tick();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
